// File: rtl/rvc_fetch_align_queue_if.sv
// Fetch/response and instruction handshake bundle for the RV32IC fetch realigner.
// master = realigner side, slave = I-cache plus decoder side.
interface rvc_fetch_align_queue_if #(
  parameter int unsigned FETCH_W = 32
);
  logic               br_taken_i;
  logic [31:0]        br_target_i;
  logic               i_cache_request;
  logic [31:0]        fetch_addr_o;
  logic               i_cache_valid;
  logic [FETCH_W-1:0] i_cache_data;
  logic               i_cache_req_kill;
  logic               i_cache_flush;
  logic               instr_valid_o;
  logic               instr_ready_i;
  logic [31:0]        instr_o;
  logic [31:0]        instr_pc_o;
  logic               instr_compressed_o;
  logic               stall_o;

  modport master (
    input  br_taken_i, br_target_i, i_cache_valid, i_cache_data, instr_ready_i,
    output i_cache_request, fetch_addr_o, i_cache_req_kill, i_cache_flush,
           instr_valid_o, instr_o, instr_pc_o, instr_compressed_o, stall_o
  );

  modport slave (
    output br_taken_i, br_target_i, i_cache_valid, i_cache_data, instr_ready_i,
    input  i_cache_request, fetch_addr_o, i_cache_req_kill, i_cache_flush,
           instr_valid_o, instr_o, instr_pc_o, instr_compressed_o, stall_o
  );
endinterface

// File: rtl/rvc_fetch_align_queue.sv
// RV32IC fetch realigner: queues 16-bit parcels from I-cache words in a circular
// buffer and presents one whole 16/32-bit instruction per cycle with its PC.
module rvc_fetch_align_queue #(
  parameter int unsigned FETCH_W  = 32,
  parameter int unsigned QDEPTH   = 8,
  parameter logic [31:0] RESET_PC = 32'h0,
  parameter bit          RVC_EN   = 1'b1
) (
  input  logic clk,
  input  logic reset,
  rvc_fetch_align_queue_if.master bus
);
  localparam int unsigned PPW  = FETCH_W / 16;
  localparam int unsigned OFFB = $clog2(FETCH_W / 8);
  localparam int unsigned PIW  = OFFB - 1;
  localparam int unsigned QW   = $clog2(QDEPTH);

  logic [15:0]    q [QDEPTH];
  logic [QW-1:0]  rptr, wptr;
  logic [QW:0]    count;
  logic [31:0]    fetch_pc, head_pc;
  logic           outstanding;

  logic [15:0]    h0, h1;
  logic           is16, valid, pop, resp;
  logic [PIW-1:0] si;
  logic [QW:0]    n_wr, n_pop, free;
  logic           unused_pc_lsb;

  assign h0    = q[rptr];
  assign h1    = q[rptr + QW'(1)];
  assign is16  = RVC_EN && (h0[1:0] != 2'b11);
  assign valid = (count != '0) && (is16 || (count > (QW+1)'(1)));

  // Instruction fields are forced to zero when nothing is presented so the
  // outputs read as reset values whenever the queue is empty.
  assign bus.instr_valid_o      = valid;
  assign bus.stall_o            = !valid;
  assign bus.instr_compressed_o = valid && is16;
  assign bus.instr_o            = !valid ? '0 : (is16 ? {16'h0, h0} : {h1, h0});
  assign bus.instr_pc_o         = valid ? head_pc : '0;

  assign free                 = (QW+1)'(QDEPTH) - count;
  assign bus.i_cache_request  = !reset && !outstanding && !bus.br_taken_i &&
                                (free >= (QW+1)'(PPW));
  assign bus.fetch_addr_o     = {fetch_pc[31:OFFB], OFFB'(0)};
  assign bus.i_cache_flush    = !reset && bus.br_taken_i;
  assign bus.i_cache_req_kill = !reset && bus.br_taken_i && outstanding && !bus.i_cache_valid;

  // Nonzero start parcel only after a redirect to a non-word-aligned target.
  assign si    = fetch_pc[OFFB-1:1];
  assign resp  = outstanding && bus.i_cache_valid && !bus.br_taken_i;
  assign pop   = valid && bus.instr_ready_i && !bus.br_taken_i;
  assign n_wr  = resp ? ((QW+1)'(PPW) - (QW+1)'(si)) : '0;
  assign n_pop = !pop ? '0 : (is16 ? (QW+1)'(1) : (QW+1)'(2));

  assign unused_pc_lsb = fetch_pc[0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      fetch_pc    <= RESET_PC;
      head_pc     <= RESET_PC;
      outstanding <= 1'b0;
    end else if (bus.br_taken_i) begin
      rptr        <= '0;
      wptr        <= '0;
      count       <= '0;
      fetch_pc    <= bus.br_target_i;
      head_pc     <= bus.br_target_i;
      outstanding <= 1'b0;
    end else begin
      if (bus.i_cache_request)
        outstanding <= 1'b1;
      else if (resp)
        outstanding <= 1'b0;
      if (resp) begin
        wptr     <= wptr + n_wr[QW-1:0];
        fetch_pc <= {fetch_pc[31:OFFB], OFFB'(0)} + 32'(FETCH_W / 8);
      end
      if (pop) begin
        rptr    <= rptr + n_pop[QW-1:0];
        head_pc <= head_pc + (is16 ? 32'd2 : 32'd4);
      end
      count <= count + n_wr - n_pop;
    end
  end

  // Parcel storage needs no reset: count gates every read.
  always_ff @(posedge clk) begin
    if (resp) begin
      for (int j = 0; j < int'(PPW); j++) begin
        if (j >= int'(si))
          q[wptr + QW'(j) - QW'(si)] <= bus.i_cache_data[j*16 +: 16];
      end
    end
  end
endmodule

// File: tb/tb_rvc_fetch_align_queue.sv
// Bench for rvc_fetch_align_queue: queue-level reference model on the 32-bit/RVC
// instance plus directed checks on 64-bit and RVC-disabled instances.
module tb_rvc_fetch_align_queue;
  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  rvc_fetch_align_queue_if #(.FETCH_W(32)) a ();
  rvc_fetch_align_queue_if #(.FETCH_W(64)) b ();
  rvc_fetch_align_queue_if #(.FETCH_W(32)) c ();

  rvc_fetch_align_queue #(.FETCH_W(32), .QDEPTH(8), .RESET_PC(32'h0), .RVC_EN(1'b1))
    dut_a (.clk(clk), .reset(reset), .bus(a.master));
  rvc_fetch_align_queue #(.FETCH_W(64), .QDEPTH(8), .RESET_PC(32'h0), .RVC_EN(1'b1))
    dut_b (.clk(clk), .reset(reset), .bus(b.master));
  rvc_fetch_align_queue #(.FETCH_W(32), .QDEPTH(8), .RESET_PC(32'h0), .RVC_EN(1'b0))
    dut_c (.clk(clk), .reset(reset), .bus(c.master));

  logic [31:0] mem_a [256];
  logic [63:0] mem_b [32];
  logic [31:0] mem_c [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Cache responders: decide at negedge, drive just after the next posedge.
  logic        nv_a = 1'b0, nv_b = 1'b0, nv_c = 1'b0;
  logic [31:0] nd_a = '0, nd_c = '0;
  logic [63:0] nd_b = '0;
  logic        pend_a = 1'b0;
  logic [31:0] paddr_a = '0;
  int          wait_a = 0;
  int          lat_a = 1;

  always @(posedge clk) begin
    #1;
    a.i_cache_valid = nv_a; a.i_cache_data = nd_a;
    b.i_cache_valid = nv_b; b.i_cache_data = nd_b;
    c.i_cache_valid = nv_c; c.i_cache_data = nd_c;
  end

  always @(negedge clk) begin
    nv_b = !reset && b.i_cache_request;
    nd_b = mem_b[b.fetch_addr_o[7:3]];
    nv_c = !reset && c.i_cache_request;
    nd_c = mem_c[c.fetch_addr_o[6:2]];
  end

  // Reference model for instance a: parcel queue plus head/fetch PCs.
  logic [15:0] mq [$];
  logic [31:0] m_hpc = '0, m_fpc = '0;
  bit          m_out = 1'b0;

  always @(negedge clk) begin
    bit mv, m16, mreq, mflush, mkill;
    logic [31:0] mi;
    if (reset) begin
      mq.delete(); m_hpc = 32'h0; m_fpc = 32'h0; m_out = 1'b0;
    end
    m16    = (mq.size() > 0) && (mq[0][1:0] != 2'b11);
    mv     = (mq.size() >= 2) || (mq.size() == 1 && m16);
    mi     = m16 ? {16'h0, mq[0]} : {mq[1], mq[0]};
    mreq   = !reset && !m_out && !a.br_taken_i && (8 - mq.size() >= 2);
    mflush = !reset && a.br_taken_i;
    mkill  = mflush && m_out && !a.i_cache_valid;
    chk("a_valid", a.instr_valid_o, mv);
    chk("a_stall", a.stall_o, !mv);
    chk("a_req", a.i_cache_request, mreq);
    chk("a_addr", a.fetch_addr_o, m_fpc & ~32'h3);
    chk("a_flush", a.i_cache_flush, mflush);
    chk("a_kill", a.i_cache_req_kill, mkill);
    if (mv) begin
      chk("a_instr", a.instr_o, mi);
      chk("a_pc", a.instr_pc_o, m_hpc);
      chk("a_comp", a.instr_compressed_o, m16);
    end
    if (!reset) begin
      if (a.br_taken_i) begin
        mq.delete(); m_hpc = a.br_target_i; m_fpc = a.br_target_i; m_out = 1'b0;
      end else begin
        if (mv && a.instr_ready_i) begin
          void'(mq.pop_front());
          if (!m16) void'(mq.pop_front());
          m_hpc = m_hpc + (m16 ? 32'd2 : 32'd4);
        end
        if (m_out && a.i_cache_valid) begin
          for (int p = int'(m_fpc[1]); p < 2; p++) mq.push_back(a.i_cache_data[p*16 +: 16]);
          m_fpc = (m_fpc & ~32'h3) + 32'd4;
          m_out = 1'b0;
        end
        if (mreq) m_out = 1'b1;
      end
    end
    // responder for a, programmable latency, cancelled by redirect
    if (reset) begin
      pend_a = 1'b0; nv_a = 1'b0;
    end else begin
      if (a.i_cache_valid || a.br_taken_i) pend_a = 1'b0;
      if (a.i_cache_request) begin
        pend_a = 1'b1; paddr_a = a.fetch_addr_o; wait_a = lat_a - 1;
      end else if (pend_a && wait_a > 0) begin
        wait_a--;
      end
      nv_a = pend_a && (wait_a == 0);
      nd_a = mem_a[paddr_a[9:2]];
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_v(input int w);
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if ((w == 0 && a.instr_valid_o) || (w == 2 && c.instr_valid_o)) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL wait_valid_timeout inst=%0d actual=no_valid required=valid", w);
    end
  endtask

  task automatic reset_pulse();
    cyc(); reset = 1'b1;
    cyc(); reset = 1'b0;
  endtask

  logic [31:0] exp_pc [6] = '{32'd0, 32'd4, 32'd6, 32'd10, 32'd12, 32'd16};
  logic [31:0] exp_in [6] = '{32'h00A00513, 32'h00004501, 32'h00B00593,
                              32'h00004585, 32'h00C00613, 32'h00000001};
  logic        exp_cm [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

  initial begin
    #100000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int nreq, n;
    reset = 1'b1;
    a.br_taken_i = 1'b0; a.br_target_i = '0; a.instr_ready_i = 1'b0;
    b.br_taken_i = 1'b0; b.br_target_i = '0; b.instr_ready_i = 1'b0;
    c.br_taken_i = 1'b0; c.br_target_i = '0; c.instr_ready_i = 1'b0;
    for (int i = 0; i < 256; i++) mem_a[i] = 32'h0001_0001;
    for (int i = 0; i < 32; i++) mem_b[i] = 64'h0001_0001_0001_0001;
    for (int i = 0; i < 32; i++) mem_c[i] = 32'h0;
    mem_a[0] = 32'h00A0_0513;
    mem_b[0] = 64'h0593_4501_00A0_0513;
    mem_b[1] = 64'h00C0_0613_4585_00B0;
    mem_c[0] = 32'h4501_4501;
    mem_c[1] = 32'h0001_0001;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", a.instr_valid_o, 1'b0);
    chk("rst_stall", a.stall_o, 1'b1);
    chk("rst_req", a.i_cache_request, 1'b0);
    chk("rst_addr", a.fetch_addr_o, 32'h0);
    chk("rst_instr", a.instr_o, 32'h0);
    chk("rst_flush", a.i_cache_flush, 1'b0);

    // T1: single 32-bit word
    cyc(); reset = 1'b0;
    wait_v(0);
    chk("t1_instr", a.instr_o, 32'h00A00513);
    chk("t1_pc", a.instr_pc_o, 32'h0);
    chk("t1_comp", a.instr_compressed_o, 1'b0);

    // T2: c.li then a 32-bit instr straddling two words
    mem_a[0] = 32'h0513_4501;
    mem_a[1] = 32'h1234_00A0;
    reset_pulse();
    wait_v(0);
    chk("t2_instr0", a.instr_o, 32'h00004501);
    chk("t2_pc0", a.instr_pc_o, 32'h0);
    chk("t2_comp0", a.instr_compressed_o, 1'b1);
    cyc(); a.instr_ready_i = 1'b1;
    cyc(); a.instr_ready_i = 1'b0;
    wait_v(0);
    chk("t2_instr1", a.instr_o, 32'h00A00513);
    chk("t2_pc1", a.instr_pc_o, 32'h2);
    chk("t2_comp1", a.instr_compressed_o, 1'b0);

    // T3: redirect to a halfword target, parcel 0 dropped
    mem_a[8'h40] = 32'h0513_FFFF;
    mem_a[8'h41] = 32'h4501_00A0;
    cyc(); a.br_taken_i = 1'b1; a.br_target_i = 32'h0000_0102;
    @(negedge clk);
    chk("t3_flush", a.i_cache_flush, 1'b1);
    cyc(); a.br_taken_i = 1'b0;
    @(negedge clk);
    chk("t3_flush_off", a.i_cache_flush, 1'b0);
    chk("t3_addr", a.fetch_addr_o, 32'h100);
    chk("t3_req", a.i_cache_request, 1'b1);
    wait_v(0);
    chk("t3_pc", a.instr_pc_o, 32'h102);
    chk("t3_instr", a.instr_o, 32'h00A00513);
    cyc(); a.instr_ready_i = 1'b1;
    cyc(); a.instr_ready_i = 1'b0;
    wait_v(0);
    chk("t3_pc2", a.instr_pc_o, 32'h106);
    chk("t3_comp2", a.instr_compressed_o, 1'b1);

    // T4: redirect coinciding with the response, then one cycle before it
    cyc(); a.br_taken_i = 1'b1; a.br_target_i = 32'h200;
    cyc(); a.br_taken_i = 1'b0;
    @(negedge clk);
    chk("t4_req", a.i_cache_request, 1'b1);
    cyc(); a.br_taken_i = 1'b1; a.br_target_i = 32'h300; lat_a = 2;
    @(negedge clk);
    chk("t4_resp_seen", a.i_cache_valid, 1'b1);
    chk("t4_nokill", a.i_cache_req_kill, 1'b0);
    chk("t4_flush", a.i_cache_flush, 1'b1);
    cyc(); a.br_taken_i = 1'b0;
    cyc(); a.br_taken_i = 1'b1; a.br_target_i = 32'h380;
    @(negedge clk);
    chk("t4_kill", a.i_cache_req_kill, 1'b1);
    cyc(); a.br_taken_i = 1'b0;
    @(negedge clk);
    chk("t4_kill_off", a.i_cache_req_kill, 1'b0);
    wait_v(0);
    chk("t4_pc", a.instr_pc_o, 32'h380);
    chk("t4_instr", a.instr_o, 32'h00000001);

    // T5: 64-bit fetch, consumer stalled then released
    reset_pulse();
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (b.i_cache_request) nreq++;
    end
    chk("t5_req_count", nreq, 2);
    cyc(); b.instr_ready_i = 1'b1;
    n = 0;
    for (int i = 0; i < 80 && n < 6; i++) begin
      @(negedge clk);
      if (b.instr_valid_o) begin
        chk($sformatf("t5_pc%0d", n), b.instr_pc_o, exp_pc[n]);
        chk($sformatf("t5_instr%0d", n), b.instr_o, exp_in[n]);
        chk($sformatf("t5_comp%0d", n), b.instr_compressed_o, exp_cm[n]);
        n++;
      end
    end
    if (n < 6) begin
      checks++; errors++;
      $display("FAIL t5_pop_timeout actual=%0d required=6", n);
    end
    cyc(); b.instr_ready_i = 1'b0;

    // T6: RVC disabled, then reset mid-stream
    reset_pulse();
    wait_v(2);
    chk("t6_instr0", c.instr_o, 32'h45014501);
    chk("t6_comp0", c.instr_compressed_o, 1'b0);
    chk("t6_pc0", c.instr_pc_o, 32'h0);
    cyc(); c.instr_ready_i = 1'b1;
    cyc(); c.instr_ready_i = 1'b0;
    wait_v(2);
    chk("t6_instr1", c.instr_o, 32'h00010001);
    chk("t6_pc1", c.instr_pc_o, 32'h4);
    cyc(); reset = 1'b1;
    #1;
    chk("t6_rst_valid", c.instr_valid_o, 1'b0);
    chk("t6_rst_stall", c.stall_o, 1'b1);
    chk("t6_rst_instr", c.instr_o, 32'h0);
    chk("t6_rst_pc", c.instr_pc_o, 32'h0);
    chk("t6_rst_req", c.i_cache_request, 1'b0);
    chk("t6_rst_addr", c.fetch_addr_o, 32'h0);
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
